// File: rtl/tbcm_arbitrated_mux.sv
// Packet-level N:1 stream mux that locks onto the arbiter's grant until the packet's last beat.
// Define TBCM_ARBITRATED_MUX_OUTPUT_REG_EN to register the output through a 2-entry skid buffer.
module tbcm_arbitrated_mux #(
  parameter int unsigned REQUESTS   = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQUESTS-1:0]            i_valid,
  output logic [REQUESTS-1:0]            o_ready,
  input  logic [REQUESTS*DATA_WIDTH-1:0] i_data,
  input  logic [REQUESTS-1:0]            i_last,
  output logic [REQUESTS-1:0]            o_request,
  input  logic [REQUESTS-1:0]            i_grant,
  output logic [REQUESTS-1:0]            o_free,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_last,
  output logic                           o_busy
);

  localparam int unsigned OwnerW = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                  state_q, state_d;
  logic [OwnerW-1:0]       owner_q, owner_d;
  logic [REQUESTS-1:0]     owner_oh;
  logic                    busy;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sink_ready;
  logic                    accept;

  assign busy   = (state_q == StBusy);
  assign o_busy = busy;
  assign accept = busy & sel_valid & sink_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    owner_oh  = '0;
    for (int unsigned k = 0; k < REQUESTS; k++) begin
      if (owner_q == OwnerW'(k)) begin
        sel_valid   = i_valid[k];
        sel_last    = i_last[k];
        sel_data    = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        owner_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    o_request = '0;
    o_ready   = '0;
    o_free    = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so requests vanish the moment the arbiter is reset.
        if (rst_n) o_request = i_valid;
        if (i_grant != '0) begin
          state_d = StBusy;
          for (int k = int'(REQUESTS) - 1; k >= 0; k--) begin
            if (i_grant[k]) owner_d = OwnerW'(k);
          end
        end
      end
      StBusy: begin
        o_ready = sink_ready ? owner_oh : '0;
        if (accept && sel_last) begin
          o_free  = owner_oh;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef TBCM_ARBITRATED_MUX_OUTPUT_REG_EN
  logic                  head_valid_q, tail_valid_q;
  logic [DATA_WIDTH:0]   head_q, tail_q;
  logic                  pop;

  // Ready depends only on buffer occupancy, breaking the i_ready -> o_ready path.
  assign sink_ready = ~tail_valid_q;
  assign pop        = head_valid_q & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_q <= 1'b0;
      tail_valid_q <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
    end else if (pop) begin
      if (tail_valid_q) begin
        head_q       <= tail_q;
        tail_valid_q <= 1'b0;
      end else begin
        head_valid_q <= accept;
        if (accept) head_q <= {sel_last, sel_data};
      end
    end else if (accept) begin
      if (!head_valid_q) begin
        head_valid_q <= 1'b1;
        head_q       <= {sel_last, sel_data};
      end else begin
        tail_valid_q <= 1'b1;
        tail_q       <= {sel_last, sel_data};
      end
    end
  end

  assign o_valid = head_valid_q;
  assign o_last  = head_q[DATA_WIDTH];
  assign o_data  = head_q[DATA_WIDTH-1:0];
`else
  assign sink_ready = i_ready;
  assign o_valid    = busy & sel_valid;
  assign o_last     = busy & sel_last;
  assign o_data     = busy ? sel_data : '0;
`endif

endmodule
